// File: rtl/alu_defs.sv
// Shared RV32IM decode definitions: opcodes, funct3/funct7 values, ALU
// operation codes and the decoded-instruction bundle. The ALU imports this
// package too, so the operation codes mean the same thing on both sides.
package alu_defs;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Integer ALU funct3
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Load / store funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // M-extension funct3
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Misc funct3 values
  localparam logic [2:0] F3_JALR  = 3'b000;
  localparam logic [2:0] F3_FENCE = 3'b000;

  // funct7
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // instr[31:7] patterns of the two legal SYSTEM instructions
  localparam logic [24:0] SYS_ECALL  = 25'h0000000;
  localparam logic [24:0] SYS_EBREAK = 25'h0002000;

  // ALU operation codes; immediate forms share the code of the register form
  typedef enum logic [5:0] {
    ALU_NONE   = 6'd0,
    ALU_LUI    = 6'd1,
    ALU_AUIPC  = 6'd2,
    ALU_JAL    = 6'd3,
    ALU_JALR   = 6'd4,
    ALU_ADD    = 6'd5,
    ALU_SUB    = 6'd6,
    ALU_SLL    = 6'd7,
    ALU_SLT    = 6'd8,
    ALU_SLTU   = 6'd9,
    ALU_BEQ    = 6'd10,
    ALU_XOR    = 6'd11,
    ALU_BNE    = 6'd12,
    ALU_LW     = 6'd13,
    ALU_SRL    = 6'd14,
    ALU_SRA    = 6'd15,
    ALU_SB     = 6'd16,
    ALU_OR     = 6'd17,
    ALU_AND    = 6'd18,
    ALU_MUL    = 6'd19,
    ALU_MULH   = 6'd20,
    ALU_MULHSU = 6'd21,
    ALU_DIV    = 6'd22,
    ALU_MULHU  = 6'd23,
    ALU_DIVU   = 6'd24,
    ALU_REM    = 6'd25,
    ALU_REMU   = 6'd26,
    ALU_BLT    = 6'd27,
    ALU_BGE    = 6'd28,
    ALU_BLTU   = 6'd29,
    ALU_BGEU   = 6'd30,
    ALU_LB     = 6'd31,
    ALU_LH     = 6'd32,
    ALU_LBU    = 6'd33,
    ALU_LHU    = 6'd34,
    ALU_SH     = 6'd35,
    ALU_SW     = 6'd36,
    ALU_FENCE  = 6'd37,
    ALU_ECALL  = 6'd38,
    ALU_EBREAK = 6'd39
  } alu_op_t;

  // Decoded instruction as handed to execute
  typedef struct packed {
    alu_op_t     alu_sel;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        use_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        illegal;
  } dec_bundle_t;

  // Immediate extraction, all sign-extended from instr[31]
  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'h000};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational RV32IM decoder. Produces the execute bundle plus
// flags telling the stage which source registers the instruction reads,
// which the load-use hazard check needs.
module instr_decoder
  import alu_defs::*;
(
  input  logic [31:0] instr,
  output dec_bundle_t bundle,
  output logic        reads_rs1,
  output logic        reads_rs2
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  alu_op_t     alu_sel;
  logic        legal;
  logic [31:0] imm_val;
  logic        use_imm;
  logic        writes_rd;
  logic        is_load;
  logic        is_store;
  logic        uses_rs1;
  logic        uses_rs2;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Classify the instruction and pick its operation code
  always_comb begin
    alu_sel   = ALU_NONE;
    legal     = 1'b0;
    imm_val   = 32'h0;
    use_imm   = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    case (opcode)
      OPC_LUI: begin
        legal = 1'b1; alu_sel = ALU_LUI; imm_val = imm_u(instr);
        use_imm = 1'b1; writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        legal = 1'b1; alu_sel = ALU_AUIPC; imm_val = imm_u(instr);
        use_imm = 1'b1; writes_rd = 1'b1;
      end
      OPC_JAL: begin
        legal = 1'b1; alu_sel = ALU_JAL; imm_val = imm_j(instr);
        use_imm = 1'b1; writes_rd = 1'b1;
      end
      OPC_JALR: begin
        legal = (funct3 == F3_JALR); alu_sel = ALU_JALR; imm_val = imm_i(instr);
        use_imm = 1'b1; writes_rd = 1'b1; uses_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        legal = 1'b1; imm_val = imm_b(instr); uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        case (funct3)
          F3_BEQ:  alu_sel = ALU_BEQ;
          F3_BNE:  alu_sel = ALU_BNE;
          F3_BLT:  alu_sel = ALU_BLT;
          F3_BGE:  alu_sel = ALU_BGE;
          F3_BLTU: alu_sel = ALU_BLTU;
          F3_BGEU: alu_sel = ALU_BGEU;
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        legal = 1'b1; imm_val = imm_i(instr); use_imm = 1'b1;
        writes_rd = 1'b1; is_load = 1'b1; uses_rs1 = 1'b1;
        case (funct3)
          F3_LB:   alu_sel = ALU_LB;
          F3_LH:   alu_sel = ALU_LH;
          F3_LW:   alu_sel = ALU_LW;
          F3_LBU:  alu_sel = ALU_LBU;
          F3_LHU:  alu_sel = ALU_LHU;
          default: legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        legal = 1'b1; imm_val = imm_s(instr); use_imm = 1'b1;
        is_store = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        case (funct3)
          F3_SB:   alu_sel = ALU_SB;
          F3_SH:   alu_sel = ALU_SH;
          F3_SW:   alu_sel = ALU_SW;
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        legal = 1'b1; imm_val = imm_i(instr); use_imm = 1'b1;
        writes_rd = 1'b1; uses_rs1 = 1'b1;
        case (funct3)
          F3_ADD_SUB: alu_sel = ALU_ADD;
          F3_SLT:     alu_sel = ALU_SLT;
          F3_SLTU:    alu_sel = ALU_SLTU;
          F3_XOR:     alu_sel = ALU_XOR;
          F3_OR:      alu_sel = ALU_OR;
          F3_AND:     alu_sel = ALU_AND;
          F3_SLL: begin
            alu_sel = ALU_SLL;
            legal   = (funct7 == F7_BASE);
          end
          F3_SRL_SRA: begin
            if (funct7 == F7_BASE)     alu_sel = ALU_SRL;
            else if (funct7 == F7_ALT) alu_sel = ALU_SRA;
            else                       legal   = 1'b0;
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_OP: begin
        legal = 1'b1; writes_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        if (funct7 == F7_MULDIV) begin
          case (funct3)
            F3_MUL:    alu_sel = ALU_MUL;
            F3_MULH:   alu_sel = ALU_MULH;
            F3_MULHSU: alu_sel = ALU_MULHSU;
            F3_MULHU:  alu_sel = ALU_MULHU;
            F3_DIV:    alu_sel = ALU_DIV;
            F3_DIVU:   alu_sel = ALU_DIVU;
            F3_REM:    alu_sel = ALU_REM;
            default:   alu_sel = ALU_REMU;
          endcase
        end else if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD_SUB: alu_sel = ALU_ADD;
            F3_SLL:     alu_sel = ALU_SLL;
            F3_SLT:     alu_sel = ALU_SLT;
            F3_SLTU:    alu_sel = ALU_SLTU;
            F3_XOR:     alu_sel = ALU_XOR;
            F3_SRL_SRA: alu_sel = ALU_SRL;
            F3_OR:      alu_sel = ALU_OR;
            default:    alu_sel = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
          alu_sel = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == F3_SRL_SRA) begin
          alu_sel = ALU_SRA;
        end else begin
          legal = 1'b0;
        end
      end
      OPC_MISC_MEM: begin
        legal = (funct3 == F3_FENCE); alu_sel = ALU_FENCE; imm_val = imm_i(instr);
      end
      OPC_SYSTEM: begin
        imm_val = imm_i(instr);
        if (instr[31:7] == SYS_ECALL) begin
          legal = 1'b1; alu_sel = ALU_ECALL;
        end else if (instr[31:7] == SYS_EBREAK) begin
          legal = 1'b1; alu_sel = ALU_EBREAK;
        end
      end
      default: legal = 1'b0;
    endcase
  end

  // Assemble the bundle; anything not legal collapses to an inert illegal op
  always_comb begin
    bundle         = '0;
    bundle.illegal = !legal;
    reads_rs1      = legal && uses_rs1;
    reads_rs2      = legal && uses_rs2;
    if (legal) begin
      bundle.alu_sel   = alu_sel;
      bundle.imm       = imm_val;
      bundle.rs1_addr  = instr[19:15];
      bundle.rs2_addr  = instr[24:20];
      bundle.rd_addr   = instr[11:7];
      bundle.use_imm   = use_imm;
      bundle.reg_write = writes_rd && (instr[11:7] != 5'd0);
      bundle.mem_read  = is_load;
      bundle.mem_write = is_store;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline register between fetch and execute: valid/ready
// handshake on both sides, load-use hazard bubble and branch flush.
module decode_stage
  import alu_defs::*;
(
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [5:0]  ex_aluSelect,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1_addr,
  output logic [4:0]  ex_rs2_addr,
  output logic [4:0]  ex_rd_addr,
  output logic [31:0] ex_pc,
  output logic        ex_use_imm,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_illegal
);

  dec_bundle_t dec_bundle;
  logic        dec_reads_rs1;
  logic        dec_reads_rs2;
  dec_bundle_t held_reg;
  logic        valid_reg;
  logic [31:0] pc_reg;
  logic        hazard;
  logic        advance;

  instr_decoder u_instr_decoder (
    .instr     (if_instr),
    .bundle    (dec_bundle),
    .reads_rs1 (dec_reads_rs1),
    .reads_rs2 (dec_reads_rs2)
  );

  // A held load whose destination the incoming instruction reads must not be
  // followed directly; the hazard clears once the load moves on
  assign hazard = if_valid && valid_reg && held_reg.mem_read &&
                  (held_reg.rd_addr != 5'd0) &&
                  ((dec_reads_rs1 && (dec_bundle.rs1_addr == held_reg.rd_addr)) ||
                   (dec_reads_rs2 && (dec_bundle.rs2_addr == held_reg.rd_addr)));

  assign advance  = !valid_reg || ex_ready;
  assign if_ready = advance && !hazard;

  // Pipeline register: reset, then flush, then accept-or-bubble when free
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      valid_reg <= 1'b0;
      held_reg  <= '0;
      pc_reg    <= 32'h0;
    end else if (flush) begin
      valid_reg <= 1'b0;
      held_reg  <= '0;
      pc_reg    <= 32'h0;
    end else if (advance) begin
      if (if_valid && !hazard) begin
        valid_reg <= 1'b1;
        held_reg  <= dec_bundle;
        pc_reg    <= if_pc;
      end else begin
        valid_reg <= 1'b0;
        held_reg  <= '0;
        pc_reg    <= 32'h0;
      end
    end
  end

  assign ex_valid     = valid_reg;
  assign ex_aluSelect = held_reg.alu_sel;
  assign ex_imm       = held_reg.imm;
  assign ex_rs1_addr  = held_reg.rs1_addr;
  assign ex_rs2_addr  = held_reg.rs2_addr;
  assign ex_rd_addr   = held_reg.rd_addr;
  assign ex_pc        = pc_reg;
  assign ex_use_imm   = held_reg.use_imm;
  assign ex_reg_write = held_reg.reg_write;
  assign ex_mem_read  = held_reg.mem_read;
  assign ex_mem_write = held_reg.mem_write;
  assign ex_illegal   = held_reg.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios, then randomized traffic checked
// against a mask/match opcode-table reference model.
module tb_decode_stage;
  import alu_defs::*;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [5:0]  ex_aluSelect;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs1_addr;
  logic [4:0]  ex_rs2_addr;
  logic [4:0]  ex_rd_addr;
  logic [31:0] ex_pc;
  logic        ex_use_imm;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_illegal;

  int tests = 0;
  int fails = 0;

  decode_stage dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .if_ready     (if_ready),
    .flush        (flush),
    .ex_ready     (ex_ready),
    .ex_valid     (ex_valid),
    .ex_aluSelect (ex_aluSelect),
    .ex_imm       (ex_imm),
    .ex_rs1_addr  (ex_rs1_addr),
    .ex_rs2_addr  (ex_rs2_addr),
    .ex_rd_addr   (ex_rd_addr),
    .ex_pc        (ex_pc),
    .ex_use_imm   (ex_use_imm),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_illegal   (ex_illegal)
  );

  always #5 CLK = ~CLK;

  // Instruction formats in the reference table
  localparam logic [2:0] FR = 3'd0, FI = 3'd1, FL = 3'd2, FS = 3'd3,
                         FB = 3'd4, FU = 3'd5, FJ = 3'd6, FN = 3'd7;

  typedef struct packed {
    logic [31:0] mask;
    logic [31:0] match;
    logic [5:0]  code;
    logic [2:0]  fmt;
  } op_t;

  typedef struct {
    logic [5:0]  alu;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        use_imm, reg_write, mem_read, mem_write, illegal;
    logic        reads1, reads2;
  } ref_t;

  op_t tbl[$];

  task automatic add_op(input logic [31:0] mask, input logic [31:0] match,
                        input logic [5:0] code, input logic [2:0] fmt);
    op_t e;
    e.mask = mask; e.match = match; e.code = code; e.fmt = fmt;
    tbl.push_back(e);
  endtask

  task automatic build_table();
    add_op(32'h0000007F, 32'h00000037, ALU_LUI,   FU);
    add_op(32'h0000007F, 32'h00000017, ALU_AUIPC, FU);
    add_op(32'h0000007F, 32'h0000006F, ALU_JAL,   FJ);
    add_op(32'h0000707F, 32'h00000067, ALU_JALR,  FI);
    add_op(32'h0000707F, 32'h00000063, ALU_BEQ,   FB);
    add_op(32'h0000707F, 32'h00001063, ALU_BNE,   FB);
    add_op(32'h0000707F, 32'h00004063, ALU_BLT,   FB);
    add_op(32'h0000707F, 32'h00005063, ALU_BGE,   FB);
    add_op(32'h0000707F, 32'h00006063, ALU_BLTU,  FB);
    add_op(32'h0000707F, 32'h00007063, ALU_BGEU,  FB);
    add_op(32'h0000707F, 32'h00000003, ALU_LB,    FL);
    add_op(32'h0000707F, 32'h00001003, ALU_LH,    FL);
    add_op(32'h0000707F, 32'h00002003, ALU_LW,    FL);
    add_op(32'h0000707F, 32'h00004003, ALU_LBU,   FL);
    add_op(32'h0000707F, 32'h00005003, ALU_LHU,   FL);
    add_op(32'h0000707F, 32'h00000023, ALU_SB,    FS);
    add_op(32'h0000707F, 32'h00001023, ALU_SH,    FS);
    add_op(32'h0000707F, 32'h00002023, ALU_SW,    FS);
    add_op(32'h0000707F, 32'h00000013, ALU_ADD,   FI);
    add_op(32'h0000707F, 32'h00002013, ALU_SLT,   FI);
    add_op(32'h0000707F, 32'h00003013, ALU_SLTU,  FI);
    add_op(32'h0000707F, 32'h00004013, ALU_XOR,   FI);
    add_op(32'h0000707F, 32'h00006013, ALU_OR,    FI);
    add_op(32'h0000707F, 32'h00007013, ALU_AND,   FI);
    add_op(32'hFE00707F, 32'h00001013, ALU_SLL,   FI);
    add_op(32'hFE00707F, 32'h00005013, ALU_SRL,   FI);
    add_op(32'hFE00707F, 32'h40005013, ALU_SRA,   FI);
    add_op(32'hFE00707F, 32'h00000033, ALU_ADD,   FR);
    add_op(32'hFE00707F, 32'h40000033, ALU_SUB,   FR);
    add_op(32'hFE00707F, 32'h00001033, ALU_SLL,   FR);
    add_op(32'hFE00707F, 32'h00002033, ALU_SLT,   FR);
    add_op(32'hFE00707F, 32'h00003033, ALU_SLTU,  FR);
    add_op(32'hFE00707F, 32'h00004033, ALU_XOR,   FR);
    add_op(32'hFE00707F, 32'h00005033, ALU_SRL,   FR);
    add_op(32'hFE00707F, 32'h40005033, ALU_SRA,   FR);
    add_op(32'hFE00707F, 32'h00006033, ALU_OR,    FR);
    add_op(32'hFE00707F, 32'h00007033, ALU_AND,   FR);
    add_op(32'hFE00707F, 32'h02000033, ALU_MUL,   FR);
    add_op(32'hFE00707F, 32'h02001033, ALU_MULH,  FR);
    add_op(32'hFE00707F, 32'h02002033, ALU_MULHSU,FR);
    add_op(32'hFE00707F, 32'h02003033, ALU_MULHU, FR);
    add_op(32'hFE00707F, 32'h02004033, ALU_DIV,   FR);
    add_op(32'hFE00707F, 32'h02005033, ALU_DIVU,  FR);
    add_op(32'hFE00707F, 32'h02006033, ALU_REM,   FR);
    add_op(32'hFE00707F, 32'h02007033, ALU_REMU,  FR);
    add_op(32'h0000707F, 32'h0000000F, ALU_FENCE, FN);
    add_op(32'hFFFFFFFF, 32'h00000073, ALU_ECALL, FN);
    add_op(32'hFFFFFFFF, 32'h00100073, ALU_EBREAK,FN);
  endtask

  // Reference decode: table lookup, immediates built arithmetically
  function automatic ref_t ref_decode(input logic [31:0] ins);
    ref_t        r;
    op_t         e;
    logic        hit;
    logic [31:0] sgn;
    r = '{default: '0};
    hit = 1'b0;
    e = '0;
    for (int k = 0; k < tbl.size(); k++)
      if ((ins & tbl[k].mask) == tbl[k].match) begin
        hit = 1'b1;
        e = tbl[k];
      end
    if (!hit) begin
      r.illegal = 1'b1;
      return r;
    end
    sgn   = ins[31] ? 32'hFFFFFFFF : 32'h0;
    r.alu = e.code;
    r.rs1 = 5'((ins >> 15) & 32'h1F);
    r.rs2 = 5'((ins >> 20) & 32'h1F);
    r.rd  = 5'((ins >> 7) & 32'h1F);
    case (e.fmt)
      FI, FL, FN: r.imm = (sgn & 32'hFFFFF000) | (ins >> 20);
      FS: r.imm = (sgn & 32'hFFFFF000) | (((ins >> 25) << 5) & 32'hFE0) | ((ins >> 7) & 32'h1F);
      FB: r.imm = (sgn & 32'hFFFFF000) | (((ins >> 7) & 32'h1) << 11) |
                  (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1);
      FU: r.imm = ins & 32'hFFFFF000;
      FJ: r.imm = (sgn & 32'hFFF00000) | (((ins >> 12) & 32'hFF) << 12) |
                  (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3FF) << 1);
      default: r.imm = 32'h0;
    endcase
    r.use_imm   = e.fmt inside {FI, FL, FS, FU, FJ};
    r.reg_write = (e.fmt inside {FR, FI, FL, FU, FJ}) && (r.rd != 5'd0);
    r.mem_read  = (e.fmt == FL);
    r.mem_write = (e.fmt == FS);
    r.reads1    = e.fmt inside {FR, FI, FL, FS, FB};
    r.reads2    = e.fmt inside {FR, FS, FB};
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, ex_valid, 0);
    check({tag, "_alu"}, ex_aluSelect, 0);
    check({tag, "_imm"}, ex_imm, 0);
    check({tag, "_rs1"}, ex_rs1_addr, 0);
    check({tag, "_rs2"}, ex_rs2_addr, 0);
    check({tag, "_rd"}, ex_rd_addr, 0);
    check({tag, "_pc"}, ex_pc, 0);
    check({tag, "_flags"}, {ex_use_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal}, 0);
  endtask

  task automatic check_bundle(input string tag, input ref_t e, input logic [31:0] pc);
    check({tag, "_alu"}, ex_aluSelect, e.alu);
    check({tag, "_illegal"}, ex_illegal, e.illegal);
    check({tag, "_reg_write"}, ex_reg_write, e.reg_write);
    check({tag, "_mem_write"}, ex_mem_write, e.mem_write);
    check({tag, "_pc"}, ex_pc, pc);
    if (!e.illegal) begin
      check({tag, "_imm"}, ex_imm, e.imm);
      check({tag, "_rs1"}, ex_rs1_addr, e.rs1);
      check({tag, "_rs2"}, ex_rs2_addr, e.rs2);
      check({tag, "_rd"}, ex_rd_addr, e.rd);
      check({tag, "_use_imm"}, ex_use_imm, e.use_imm);
      check({tag, "_mem_read"}, ex_mem_read, e.mem_read);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    if_valid = v; if_instr = ins; if_pc = pc; ex_ready = rdy; flush = fl;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic        m_valid;
    ref_t        m_b;
    logic [31:0] m_pc;
    ref_t        inc;
    logic        hz;
    logic [31:0] ins;
    logic [31:0] tmp;
    op_t         e;

    build_table();
    drive(0, 32'h0, 32'h0, 1, 0);
    RESET_N = 1'b0;
    #2;
    check_zero("reset");
    check("reset_if_ready", if_ready, 1);
    tick(); tick();
    RESET_N = 1'b1;
    $display("[TB] reset released");

    // addi x1,x0,5
    drive(1, 32'h00500093, 32'h100, 1, 0);
    #1 check("addi_if_ready", if_ready, 1);
    tick();
    $display("[TB] addi x1,x0,5 issued");
    check("addi_valid", ex_valid, 1);
    check("addi_alu", ex_aluSelect, 6'b000101);
    check("addi_imm", ex_imm, 5);
    check("addi_rd", ex_rd_addr, 1);
    check("addi_use_imm", ex_use_imm, 1);
    check("addi_reg_write", ex_reg_write, 1);
    check("addi_pc", ex_pc, 32'h100);

    // lui x2,0xA
    drive(1, 32'h0000A137, 32'h104, 1, 0);
    tick();
    $display("[TB] lui x2,0xA issued");
    check("lui_alu", ex_aluSelect, 6'b000001);
    check("lui_imm", ex_imm, 32'h0000A000);
    check("lui_rd", ex_rd_addr, 2);

    // lw x3,4(x1) then add x4,x3,x2: one hazard cycle, one bubble
    drive(1, 32'h0040A183, 32'h108, 1, 0);
    tick();
    $display("[TB] lw x3,4(x1) issued");
    check("lw_alu", ex_aluSelect, 6'b001101);
    check("lw_mem_read", ex_mem_read, 1);
    check("lw_imm", ex_imm, 4);
    drive(1, 32'h00218233, 32'h10C, 1, 0);
    #1 check("hazard_if_ready", if_ready, 0);
    tick();
    $display("[TB] add x4,x3,x2 stalled one cycle");
    check("bubble_valid", ex_valid, 0);
    check("after_bubble_if_ready", if_ready, 1);
    tick();
    $display("[TB] add x4,x3,x2 issued");
    check("add_valid", ex_valid, 1);
    check("add_alu", ex_aluSelect, 6'b000101);
    check("add_rs1", ex_rs1_addr, 3);
    check("add_rs2", ex_rs2_addr, 2);
    check("add_rd", ex_rd_addr, 4);
    check("add_use_imm", ex_use_imm, 0);
    check("add_imm", ex_imm, 0);
    check("add_pc", ex_pc, 32'h10C);

    // mul held for three cycles of backpressure
    drive(1, 32'h022081B3, 32'h110, 1, 0);
    tick();
    drive(1, 32'h00100293, 32'h114, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 check("mul_if_ready", if_ready, 0);
      tick();
      $display("[TB] mul held, stall cycle %0d", i);
      check("mul_valid", ex_valid, 1);
      check("mul_alu", ex_aluSelect, 6'b010011);
      check("mul_regs", {ex_rs1_addr, ex_rs2_addr, ex_rd_addr}, {5'd1, 5'd2, 5'd3});
      check("mul_pc", ex_pc, 32'h110);
      check("mul_imm", ex_imm, 0);
    end
    drive(0, 32'h0, 32'h0, 1, 0);
    tick();
    check("mul_drain_valid", ex_valid, 0);

    // beq held under backpressure, then flushed
    drive(1, 32'h00208463, 32'h200, 1, 0);
    tick();
    $display("[TB] beq x1,x2,+8 issued");
    check("beq_alu", ex_aluSelect, 6'b001010);
    check("beq_imm", ex_imm, 8);
    check("beq_reg_write", ex_reg_write, 0);
    drive(1, 32'h00100293, 32'h204, 0, 1);
    tick();
    $display("[TB] flush while beq held");
    check("flush_valid", ex_valid, 0);

    // all-ones word is illegal
    drive(1, 32'hFFFFFFFF, 32'h300, 1, 0);
    tick();
    $display("[TB] 0xFFFFFFFF issued");
    check("illegal_valid", ex_valid, 1);
    check("illegal_flag", ex_illegal, 1);
    check("illegal_reg_write", ex_reg_write, 0);
    check("illegal_mem_write", ex_mem_write, 0);
    check("illegal_alu", ex_aluSelect, 0);

    // reset pulsed mid-stall
    drive(1, 32'h022081B3, 32'h400, 1, 0);
    tick();
    drive(1, 32'h00100293, 32'h404, 0, 0);
    tick();
    check("stall_before_reset", ex_valid, 1);
    RESET_N = 1'b0;
    #1;
    $display("[TB] reset asserted mid-stall");
    check_zero("midreset");
    tick();
    RESET_N = 1'b1;
    #1 check("post_reset_if_ready", if_ready, 1);
    tick();
    check("post_reset_valid", ex_valid, 1);
    check("post_reset_pc", ex_pc, 32'h404);
    check("post_reset_alu", ex_aluSelect, 6'b000101);

    // randomized traffic against the reference model
    m_valid = 1'b1;
    m_b     = ref_decode(32'h00100293);
    m_pc    = 32'h404;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        ins = $urandom;
      end else begin
        e   = tbl[$urandom_range(0, tbl.size() - 1)];
        tmp = $urandom;
        tmp[24:20] = 5'($urandom_range(0, 3));
        tmp[19:15] = 5'($urandom_range(0, 3));
        tmp[11:7]  = 5'($urandom_range(0, 3));
        ins = e.match | (tmp & ~e.mask);
      end
      drive($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0);
      #1;
      inc = ref_decode(ins);
      hz  = if_valid && m_valid && m_b.mem_read && (m_b.rd != 5'd0) &&
            ((inc.reads1 && inc.rs1 == m_b.rd) || (inc.reads2 && inc.rs2 == m_b.rd));
      check("rnd_if_ready", if_ready, (!m_valid || ex_ready) && !hz);
      if (flush) begin
        m_valid = 1'b0;
      end else if (!m_valid || ex_ready) begin
        if (if_valid && !hz) begin
          m_valid = 1'b1;
          m_b     = inc;
          m_pc    = if_pc;
          $display("[TB] cycle %0d accept pc=%08h instr=%08h", c, if_pc, ins);
        end else begin
          m_valid = 1'b0;
        end
      end
      tick();
      check("rnd_valid", ex_valid, m_valid);
      if (m_valid) check_bundle("rnd", m_b, m_pc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 RESET_N  input  1  asynchronous active-low reset.
REQ-004 if_valid  input  1  fetch presents an instruction.
REQ-005 if_instr  input  32  RV32IM instruction word.
REQ-006 if_pc  input  32  PC of if_instr.
REQ-007 if_ready  output  1  decode accepts if_instr this cycle.
REQ-008 flush  input  1  discard held and incoming instruction (taken branch/jump).
REQ-009 ex_ready  input  1  execute stage accepts ex_* this cycle.
REQ-010 ex_valid  output  1  ex_* bundle valid.
REQ-011 ex_aluSelect  output  6  ALU operation code.
REQ-012 ex_imm  output  32  sign-extended immediate (U: imm<<12).
REQ-013 ex_rs1_addr, ex_rs2_addr, ex_rd_addr  output  5 each  register indices.
REQ-014 ex_pc  output  32  PC of the held instruction.
REQ-015 ex_use_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal  output  1 each  operand select and control flags.

Function
REQ-016 The block SHALL be a single pipeline register: an instruction is accepted on an edge where if_valid && if_ready, and its decoded bundle appears at ex_* one cycle later.
REQ-017 if_ready SHALL equal (!ex_valid || ex_ready) && !hazard, where hazard is combinational.
REQ-018 While ex_valid && !ex_ready, all ex_* outputs SHALL hold stable.
REQ-019 aluSelect codes SHALL be: LUI 000001, JAL 000011, JALR 000100, ADD 000101, SUB 000110, BEQ 001010, BNE 001100, LW 001101, SB 010000, MUL 010011, DIV 010110; all other RV32IM operations SHALL use unique package-defined codes.
REQ-020 Immediates SHALL follow RV32 I/S/B/U/J formats with bit 31 sign extension; R-type SHALL output ex_imm = 0 and ex_use_imm = 0.
REQ-021 Opcodes, funct3 values or funct7 values not in RV32IM SHALL set ex_illegal = 1, ex_reg_write = 0, ex_mem_write = 0 and ex_aluSelect = 000000.
REQ-022 Load-use hazard: when ex_valid, ex_mem_read, ex_rd_addr != 0, and the incoming instruction reads that register through rs1, or through rs2 for R/S/B types, hazard SHALL be 1 for exactly one cycle.
REQ-023 While hazard is 1, the block SHALL deassert if_ready and, on the next edge where ex_ready = 1, load a bubble (ex_valid = 0).
REQ-024 flush SHALL take priority over everything else: on the next edge ex_valid becomes 0 and the incoming instruction is dropped, regardless of ex_ready.
REQ-025 Writes to x0 SHALL decode with ex_reg_write = 0.
REQ-026 Reset SHALL dominate flush, and flush SHALL dominate accept.

Reset
REQ-027 While RESET_N = 0, the block SHALL drive ex_valid = 0, every ex_* data/control output = 0, and ex_aluSelect = 000000.
REQ-028 Reset asserted mid-stall SHALL discard the held instruction; on the first edge after release, if_ready SHALL be 1.

Structure
REQ-029 The aluSelect codes, opcode constants and funct3/funct7 constants SHALL reside in a shared package, alu_defs, which the ALU also uses.
REQ-030 Combinational decode SHALL be a sub-module, instr_decoder; hazard logic, handshake and the register SHALL be in decode_stage.

Verification
REQ-031 Verification SHALL cover: addi x1,x0,5 (0x00500093) with ex_ready = 1 -> next cycle ex_valid = 1, ex_aluSelect = 000101, ex_imm = 5, ex_rd_addr = 1, ex_use_imm = 1.
REQ-032 Verification SHALL cover: lui x2,0xA (0x0000A137) -> ex_aluSelect = 000001, ex_imm = 0x0000A000.
REQ-033 Verification SHALL cover: lw x3,4(x1) followed by add x4,x3,x2 -> if_ready = 0 for one cycle, one bubble, then add issued with ex_rs1_addr = 3.
REQ-034 Verification SHALL cover: ex_ready = 0 for 3 cycles while holding mul (0x022081B3) -> ex_* stable, ex_aluSelect = 010011, if_ready = 0.
REQ-035 Verification SHALL cover: flush asserted while beq is held and ex_ready = 0 -> ex_valid = 0 on the next edge.
REQ-036 Verification SHALL cover: instruction 0xFFFFFFFF -> ex_illegal = 1, ex_reg_write = 0; and RESET_N pulsed low mid-stall -> all outputs 0 immediately.
